// File: rtl/env_generator_if.sv
// Operator-bank envelope bus: sample-slot control and per-operator parameters
// in, rate request and registered envelope out.
interface env_generator_if #(
  parameter int ENV_WIDTH = 9,
  parameter int OVF_WIDTH = 3
);
  logic                 sample_clk_en;
  logic [4:0]           op_num;
  logic                 key_on;
  logic [3:0]           ar;
  logic [3:0]           dr;
  logic [3:0]           sl;
  logic [3:0]           rr;
  logic                 eg_type;
  logic [OVF_WIDTH-1:0] rate_counter_overflow;
  logic [3:0]           requested_rate;
  logic [ENV_WIDTH-1:0] env;
  logic [1:0]           env_state;

  modport master (
    output sample_clk_en, op_num, key_on, ar, dr, sl, rr, eg_type,
           rate_counter_overflow,
    input  requested_rate, env, env_state
  );

  modport slave (
    input  sample_clk_en, op_num, key_on, ar, dr, sl, rr, eg_type,
           rate_counter_overflow,
    output requested_rate, env, env_state
  );
endinterface

// File: rtl/env_generator.sv
// Time-multiplexed ADSR envelope generator for one OPL2 operator bank; one
// operator is stepped per update slot using the rate counter's overflow count.
module env_generator #(
  parameter int NUM_OPS   = 18,
  parameter int ENV_WIDTH = 9,
  parameter int OVF_WIDTH = 3
) (
  input  logic            clk,
  input  logic            rst,
  env_generator_if.slave  bus
);

  localparam int IDX_W  = $clog2(NUM_OPS);
  localparam int PROD_W = ENV_WIDTH + OVF_WIDTH;
  localparam logic [ENV_WIDTH-1:0] ENV_MAX = {ENV_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_ATTACK  = 2'd0,
    ST_DECAY   = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_e;

  // e + ov computed one bit wider, clamped to full attenuation.
  function automatic logic [ENV_WIDTH-1:0] sat_add(
    input logic [ENV_WIDTH-1:0] e,
    input logic [OVF_WIDTH-1:0] ov
  );
    logic [ENV_WIDTH:0] sum;
    sum = {1'b0, e} + (ENV_WIDTH+1)'(ov);
    return sum[ENV_WIDTH] ? ENV_MAX : sum[ENV_WIDTH-1:0];
  endfunction

  // Exponential attack step; a nonzero overflow always makes progress.
  function automatic logic [ENV_WIDTH-1:0] attack_step(
    input logic [ENV_WIDTH-1:0] e,
    input logic [OVF_WIDTH-1:0] ov
  );
    logic [PROD_W-1:0]    prod;
    logic [ENV_WIDTH-1:0] step;
    prod = PROD_W'(e) * PROD_W'(ov);
    step = prod[PROD_W-1:3];
    if ((ov != '0) && (step == '0) && (e != '0)) begin
      step = ENV_WIDTH'(1);
    end else begin
      step = step;
    end
    return step;
  endfunction

  function automatic logic [ENV_WIDTH-1:0] decay_target(input logic [3:0] sl);
    return (sl == 4'd15) ? ENV_MAX : ENV_WIDTH'({sl, 4'b0000});
  endfunction

  env_state_e           r_state    [NUM_OPS];
  logic [ENV_WIDTH-1:0] r_env      [NUM_OPS];
  logic                 r_key_prev [NUM_OPS];
  logic                 r_sample_clk_en_d0;
  logic [ENV_WIDTH-1:0] r_env_out;
  env_state_e           r_env_state_out;

  logic                 w_upd;
  logic                 w_op_valid;
  logic [IDX_W-1:0]     w_idx;
  env_state_e           w_cur_state;
  logic [ENV_WIDTH-1:0] w_cur_env;
  logic                 w_cur_kp;
  logic [ENV_WIDTH-1:0] w_sat_sum;
  logic [ENV_WIDTH-1:0] w_att_env;
  logic [ENV_WIDTH-1:0] w_target;
  env_state_e           w_state_nxt;
  logic [ENV_WIDTH-1:0] w_env_nxt;
  logic [3:0]           w_rate;

  assign w_upd       = r_sample_clk_en_d0;
  assign w_op_valid  = (int'(bus.op_num) < NUM_OPS);
  assign w_idx       = w_op_valid ? bus.op_num[IDX_W-1:0] : '0;
  assign w_cur_state = w_op_valid ? r_state[w_idx] : ST_RELEASE;
  assign w_cur_env   = w_op_valid ? r_env[w_idx] : ENV_MAX;
  assign w_cur_kp    = w_op_valid ? r_key_prev[w_idx] : 1'b0;
  assign w_sat_sum   = sat_add(w_cur_env, bus.rate_counter_overflow);
  assign w_att_env   = w_cur_env - attack_step(w_cur_env, bus.rate_counter_overflow);
  assign w_target    = decay_target(bus.sl);

  // Rate selection for the rate counter, from the serviced operator's state.
  always_comb begin
    w_rate = bus.rr;
    case (w_cur_state)
      ST_ATTACK:  w_rate = bus.ar;
      ST_DECAY:   w_rate = bus.dr;
      ST_SUSTAIN: w_rate = bus.eg_type ? 4'd0 : bus.rr;
      ST_RELEASE: w_rate = bus.rr;
      default:    w_rate = bus.rr;
    endcase
  end

  assign bus.requested_rate = w_rate;

  // Next envelope value and state; key edges take priority over the ADSR step.
  always_comb begin
    w_state_nxt = w_cur_state;
    w_env_nxt   = w_cur_env;
    if (bus.key_on && !w_cur_kp) begin
      if (bus.ar == 4'd15) begin
        w_env_nxt   = '0;
        w_state_nxt = ST_DECAY;
      end else begin
        w_state_nxt = ST_ATTACK;
      end
    end else if (!bus.key_on && w_cur_kp) begin
      w_state_nxt = ST_RELEASE;
    end else begin
      case (w_cur_state)
        ST_ATTACK: begin
          w_env_nxt = w_att_env;
          if (w_att_env == '0) begin
            w_state_nxt = ST_DECAY;
          end else begin
            w_state_nxt = ST_ATTACK;
          end
        end
        ST_DECAY: begin
          if (w_sat_sum >= w_target) begin
            w_env_nxt   = w_target;
            w_state_nxt = ST_SUSTAIN;
          end else begin
            w_env_nxt   = w_sat_sum;
          end
        end
        ST_SUSTAIN: begin
          if (!bus.eg_type) begin
            w_env_nxt = w_sat_sum;
          end else begin
            w_env_nxt = w_cur_env;
          end
        end
        ST_RELEASE: w_env_nxt = w_sat_sum;
        default: begin
          w_env_nxt   = ENV_MAX;
          w_state_nxt = ST_RELEASE;
        end
      endcase
    end
  end

  // Per-operator state and output registers, written only on a valid update slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample_clk_en_d0 <= 1'b0;
      r_env_out          <= ENV_MAX;
      r_env_state_out    <= ST_RELEASE;
      for (int i = 0; i < NUM_OPS; i++) begin
        r_state[i]    <= ST_RELEASE;
        r_env[i]      <= ENV_MAX;
        r_key_prev[i] <= 1'b0;
      end
    end else begin
      r_sample_clk_en_d0 <= bus.sample_clk_en;
      if (w_upd && w_op_valid) begin
        r_state[w_idx]    <= w_state_nxt;
        r_env[w_idx]      <= w_env_nxt;
        r_key_prev[w_idx] <= bus.key_on;
        r_env_out         <= w_env_nxt;
        r_env_state_out   <= w_state_nxt;
      end
    end
  end

  assign bus.env       = r_env_out;
  assign bus.env_state = r_env_state_out;

endmodule

// File: tb/tb_env_generator.sv
// Self-checking bench for env_generator: directed envelope scenarios followed by
// randomized slots, all compared against an integer-arithmetic envelope model.
module tb_env_generator;

  localparam int NOPS = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  env_generator_if #(.ENV_WIDTH(9), .OVF_WIDTH(3)) bus ();

  env_generator #(.NUM_OPS(NOPS), .ENV_WIDTH(9), .OVF_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer envelope per operator.
  int m_state [NOPS];
  int m_env   [NOPS];
  bit m_kp    [NOPS];
  int m_out_env;
  int m_out_state;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NOPS; i++) begin
      m_state[i] = 3; m_env[i] = 511; m_kp[i] = 1'b0;
    end
    m_out_env = 511; m_out_state = 3;
  endfunction

  function automatic int model_rate(int op, int a, int d, int r, bit eg);
    case (m_state[op])
      0: return a;
      1: return d;
      2: return eg ? 0 : r;
      default: return r;
    endcase
  endfunction

  function automatic void model_upd(int op, bit key, int a, int s, bit eg, int ov);
    int e, st, step, tgt;
    if (op >= NOPS) return;
    e = m_env[op]; st = m_state[op];
    if (key && !m_kp[op]) begin
      if (a == 15) begin e = 0; st = 1; end
      else st = 0;
    end else if (!key && m_kp[op]) begin
      st = 3;
    end else if (st == 0) begin
      step = (e * ov) / 8;
      if (ov != 0 && step == 0 && e != 0) step = 1;
      e = e - step;
      if (e == 0) st = 1;
    end else if (st == 1) begin
      tgt = (s == 15) ? 511 : s * 16;
      e = (e + ov > 511) ? 511 : e + ov;
      if (e >= tgt) begin e = tgt; st = 2; end
    end else if (st == 2) begin
      if (!eg) e = (e + ov > 511) ? 511 : e + ov;
    end else begin
      e = (e + ov > 511) ? 511 : e + ov;
    end
    m_env[op] = e; m_state[op] = st; m_kp[op] = key;
    m_out_env = e; m_out_state = st;
  endfunction

  // One service slot: strobe, hold inputs through the update cycle, then compare.
  task automatic do_slot(input int op, input bit key, input int a, input int d,
                         input int s, input int r, input bit eg, input int ov);
    @(negedge clk);
    bus.op_num = 5'(op); bus.key_on = key;
    bus.ar = 4'(a); bus.dr = 4'(d); bus.sl = 4'(s); bus.rr = 4'(r);
    bus.eg_type = eg; bus.rate_counter_overflow = 3'(ov);
    bus.sample_clk_en = 1'b1;
    #1;
    if (op < NOPS) chk_eq("requested_rate", int'(bus.requested_rate), model_rate(op, a, d, r, eg));
    @(negedge clk);
    bus.sample_clk_en = 1'b0;
    @(negedge clk);
    model_upd(op, key, a, s, eg, ov);
    chk_eq("env", int'(bus.env), m_out_env);
    chk_eq("env_state", int'(bus.env_state), m_out_state);
  endtask

  // Reset asserted on the same cycle as a slot strobe, so that slot never updates.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.sample_clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.sample_clk_en = 1'b0;
    model_reset();
    chk_eq("rst_env", int'(bus.env), 511);
    chk_eq("rst_state", int'(bus.env_state), 3);
  endtask

  int att_exp [9] = '{256, 128, 64, 32, 16, 8, 4, 2, 1};
  bit r_key   [20];

  initial begin
    bus.sample_clk_en = 1'b0; bus.op_num = 5'd0; bus.key_on = 1'b0;
    bus.ar = 4'd0; bus.dr = 4'd0; bus.sl = 4'd0; bus.rr = 4'd0;
    bus.eg_type = 1'b0; bus.rate_counter_overflow = 3'd0;
    repeat (2) @(negedge clk);
    do_reset();

    // Idle after reset: every operator silent in RELEASE.
    for (int op = 0; op < NOPS; op++)
      do_slot(op, 1'b0, 2, 3, 4, $urandom_range(0, 15), 1'b0, 0);

    // op 3: instant attack, decay by 2 up to the sustain level of 64.
    do_slot(3, 1'b1, 15, 5, 4, 7, 1'b1, 0);
    chk_eq("op3_keyon_env", int'(bus.env), 0);
    chk_eq("op3_keyon_state", int'(bus.env_state), 1);
    for (int k = 0; k < 32; k++) do_slot(3, 1'b1, 15, 5, 4, 7, 1'b1, 2);
    chk_eq("op3_sus_env", int'(bus.env), 64);
    chk_eq("op3_sus_state", int'(bus.env_state), 2);
    do_slot(3, 1'b1, 15, 5, 4, 7, 1'b1, 3);
    chk_eq("op3_hold_env", int'(bus.env), 64);

    // op 5: exponential attack from 511, forced unit step at e=1.
    do_slot(5, 1'b1, 8, 2, 4, 7, 1'b1, 0);
    chk_eq("op5_keyon_state", int'(bus.env_state), 0);
    for (int k = 0; k < 9; k++) begin
      do_slot(5, 1'b1, 8, 2, 4, 7, 1'b1, 4);
      chk_eq("op5_attack_env", int'(bus.env), att_exp[k]);
    end
    do_slot(5, 1'b1, 8, 2, 4, 7, 1'b1, 1);
    chk_eq("op5_force_env", int'(bus.env), 0);
    chk_eq("op5_force_state", int'(bus.env_state), 1);

    // op 7: percussive sustain then release, saturating at 511.
    do_slot(7, 1'b1, 15, 2, 0, 6, 1'b0, 0);
    do_slot(7, 1'b1, 15, 2, 0, 6, 1'b0, 0);
    chk_eq("op7_sus_state", int'(bus.env_state), 2);
    for (int k = 0; k < 3; k++) do_slot(7, 1'b1, 15, 2, 0, 6, 1'b0, 5);
    chk_eq("op7_sus_env", int'(bus.env), 15);
    do_slot(7, 1'b0, 15, 2, 0, 6, 1'b0, 7);
    chk_eq("op7_keyoff_env", int'(bus.env), 15);
    chk_eq("op7_keyoff_state", int'(bus.env_state), 3);
    for (int k = 0; k < 75; k++) do_slot(7, 1'b0, 15, 2, 0, 6, 1'b0, 7);
    chk_eq("op7_sat_env", int'(bus.env), 511);

    // op 2 edges interleaved with op 9, then an out-of-range operator.
    do_slot(2, 1'b1, 15, 1, 8, 4, 1'b1, 3);
    do_slot(9, 1'b1, 3, 1, 8, 4, 1'b1, 3);
    do_slot(2, 1'b0, 15, 1, 8, 4, 1'b1, 0);
    do_slot(9, 1'b1, 3, 1, 8, 4, 1'b1, 5);
    do_slot(2, 1'b0, 15, 1, 8, 4, 1'b1, 0);
    do_slot(20, 1'b1, 15, 1, 8, 4, 1'b1, 7);
    chk_eq("op20_hold_env", int'(bus.env), 0);
    chk_eq("op20_hold_state", int'(bus.env_state), 3);

    // op 4: reset in mid-attack with key held; attack restarts afterwards.
    do_slot(4, 1'b1, 5, 1, 8, 4, 1'b1, 0);
    do_slot(4, 1'b1, 5, 1, 8, 4, 1'b1, 3);
    chk_eq("op4_mid_attack_env", int'(bus.env), 320);
    bus.op_num = 5'd4; bus.key_on = 1'b1;
    do_reset();
    do_slot(4, 1'b1, 5, 1, 8, 4, 1'b1, 3);
    chk_eq("op4_restart_state", int'(bus.env_state), 0);
    chk_eq("op4_restart_env", int'(bus.env), 511);

    // Randomized slots over all operators including out-of-range ones.
    for (int i = 0; i < 20; i++) r_key[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      int op;
      op = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19)
                                       : (($urandom_range(0, 1) == 0) ? 2 : 9);
      if ($urandom_range(0, 5) == 0) r_key[op] = ~r_key[op];
      do_slot(op, r_key[op], $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
